// File: rtl/eth_egress_arbiter.sv
// rtl/eth_egress_arbiter.sv - packet-granular round-robin egress arbiter
//
// Grants one ingress queue at a time and pops it until that packet's eop word,
// forwarding each popped word one cycle later on the o_out* outputs.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_pkt_avail       per queue: at least one complete packet queued
//   i_fifo_empty      per queue: queue empty
//   i_fifo_data       per queue head word, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_fifo_sop/eop    per queue head-word framing flags
//   o_rd_en           per queue pop strobe, one-hot or zero
//   i_out_ready       downstream accepts a word next cycle
//   o_outdata         forwarded word (holds when no word is forwarded)
//   o_outvalid        o_outdata valid this cycle
//   o_outsop/o_outeop framing of the forwarded word
//   o_grant_id        current or last granted queue
//   o_busy            transferring a packet
//   o_err_framing     pulse: sop missing on first word or present on a later one
//   o_err_timeout     pulse: packet cut at MAX_PKT_WORDS with a forced eop

module eth_egress_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int PORT_COUNT    = 2,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [PORT_COUNT-1:0]            i_pkt_avail,
  input  logic [PORT_COUNT-1:0]            i_fifo_empty,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] i_fifo_data,
  input  logic [PORT_COUNT-1:0]            i_fifo_sop,
  input  logic [PORT_COUNT-1:0]            i_fifo_eop,
  output logic [PORT_COUNT-1:0]            o_rd_en,
  input  logic                             i_out_ready,
  output logic [DATA_WIDTH-1:0]            o_outdata,
  output logic                             o_outvalid,
  output logic                             o_outsop,
  output logic                             o_outeop,
  output logic [((PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1)-1:0] o_grant_id,
  output logic                             o_busy,
  output logic                             o_err_framing,
  output logic                             o_err_timeout
);

  localparam int GW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam int CW = $clog2(MAX_PKT_WORDS) + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                r_state;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_last_grant;
  logic [CW-1:0]         r_word_cnt;
  logic [DATA_WIDTH-1:0] r_outdata;
  logic                  r_outvalid;
  logic                  r_outsop;
  logic                  r_outeop;
  logic                  r_err_framing;
  logic                  r_err_timeout;

  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_sop;
  logic                  w_eop;
  logic                  w_first;
  logic                  w_timeout;
  logic                  w_found;
  logic [GW-1:0]         w_sel;
  logic [GW-1:0]         w_idx;

  // Pop is gated by reset so a mid-packet reset never steals a word.
  assign w_pop     = (r_state == XFER) && !i_fifo_empty[r_grant] && i_out_ready && !i_rst;
  assign w_word    = i_fifo_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sop     = i_fifo_sop[r_grant];
  assign w_eop     = i_fifo_eop[r_grant];
  assign w_first   = (r_word_cnt == '0);
  // The MAX_PKT_WORDS-th word of a packet without eop terminates it.
  assign w_timeout = w_pop && !w_eop && (r_word_cnt == CW'(MAX_PKT_WORDS - 1));

  assign o_rd_en = w_pop ? (PORT_COUNT'(1) << r_grant) : '0;

  // Round-robin search starting just after the last granted queue.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= PORT_COUNT; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % PORT_COUNT);
      if (!w_found && i_pkt_avail[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last_grant  <= GW'(PORT_COUNT - 1);
      r_word_cnt    <= '0;
      r_outdata     <= '0;
      r_outvalid    <= 1'b0;
      r_outsop      <= 1'b0;
      r_outeop      <= 1'b0;
      r_err_framing <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_outvalid    <= w_pop;
      r_outsop      <= w_pop && w_sop;
      r_outeop      <= w_pop && (w_eop || w_timeout);
      r_err_framing <= w_pop && (w_first ? !w_sop : w_sop);
      r_err_timeout <= w_timeout;
      if (w_pop) begin
        r_outdata <= w_word;
      end

      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_word_cnt   <= '0;
            r_state      <= XFER;
          end
        end
        XFER: begin
          if (w_pop) begin
            if (r_word_cnt != '1) begin
              r_word_cnt <= r_word_cnt + CW'(1);
            end
            if (w_eop || w_timeout) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_outdata     = r_outdata;
  assign o_outvalid    = r_outvalid;
  assign o_outsop      = r_outsop;
  assign o_outeop      = r_outeop;
  assign o_grant_id    = r_grant;
  assign o_busy        = (r_state == XFER);
  assign o_err_framing = r_err_framing;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_eth_egress_arbiter.sv
// tb/tb_eth_egress_arbiter.sv - self-checking bench for eth_egress_arbiter

module tb_eth_egress_arbiter;

  localparam int DW   = 32;
  localparam int NP   = 2;
  localparam int MAXW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     pkt_avail, fifo_empty, fifo_sop, fifo_eop, rd_en;
  logic [NP*DW-1:0]  fifo_data;
  logic              out_ready;
  logic [DW-1:0]     outdata;
  logic              outvalid, outsop, outeop, busy, err_framing, err_timeout;
  logic [0:0]        grant_id;

  always #5 clk = ~clk;

  eth_egress_arbiter #(.DATA_WIDTH(DW), .PORT_COUNT(NP), .MAX_PKT_WORDS(MAXW)) dut (
    .i_clk(clk), .i_rst(rst), .i_pkt_avail(pkt_avail), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .i_fifo_sop(fifo_sop), .i_fifo_eop(fifo_eop),
    .o_rd_en(rd_en), .i_out_ready(out_ready), .o_outdata(outdata),
    .o_outvalid(outvalid), .o_outsop(outsop), .o_outeop(outeop),
    .o_grant_id(grant_id), .o_busy(busy), .o_err_framing(err_framing),
    .o_err_timeout(err_timeout)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } word_t;

  // Ingress queues (environment) and complete-packet counts.
  word_t         fq [NP][$];
  int            npkts [NP];
  logic [NP-1:0] force_avail;

  // Reference model: transfer bookkeeping plus expected output registers.
  bit            m_busy;
  int            m_grant, m_last, m_cnt;
  logic [DW-1:0] e_data;
  logic          e_valid, e_sop, e_eop, e_fr, e_to;

  int  n_checks, n_pass;
  int  dut_grants[$];
  bit  prev_busy;
  int  n_fr, n_to;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_last = NP - 1; m_cnt = 0;
    e_data = '0; e_valid = 0; e_sop = 0; e_eop = 0; e_fr = 0; e_to = 0;
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      if (fq[i].size() == 0) begin
        fifo_data[i*DW +: DW] = '0;
        fifo_sop[i] = 1'b0;
        fifo_eop[i] = 1'b0;
      end else begin
        fifo_data[i*DW +: DW] = fq[i][0].d;
        fifo_sop[i] = fq[i][0].s;
        fifo_eop[i] = fq[i][0].e;
      end
      pkt_avail[i] = (npkts[i] > 0) || force_avail[i];
    end
  endtask

  // bad: 0 good framing, 1 first word lacks sop, 2 extra sop on last word
  task automatic push_pkt(input int p, input int len, input int bad, input bit has_eop);
    for (int w = 0; w < len; w++) begin
      word_t x;
      x.d = $urandom;
      x.s = ((w == 0) && bad != 1) || ((w == len - 1) && w > 0 && bad == 2);
      x.e = has_eop && (w == len - 1);
      fq[p].push_back(x);
    end
    if (has_eop) npkts[p]++;
  endtask

  // One clock: compare at negedge, advance the model, then apply pops after the edge.
  task automatic step();
    logic [NP-1:0] exp_rd, popv;
    word_t w;
    bit found;
    drive_fifo();
    @(negedge clk);
    check("outvalid", outvalid, e_valid);
    check("outdata", outdata, e_data);
    check("outsop", outsop, e_sop);
    check("outeop", outeop, e_eop);
    check("err_framing", err_framing, e_fr);
    check("err_timeout", err_timeout, e_to);
    check("busy", busy, m_busy);
    check("grant_id", grant_id, m_grant);
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
    prev_busy = busy;
    if (err_framing) n_fr++;
    if (err_timeout) n_to++;

    exp_rd = '0;
    if (!rst && m_busy && fq[m_grant].size() > 0 && out_ready) exp_rd[m_grant] = 1'b1;
    check("rd_en", rd_en, exp_rd);

    if (rst) begin
      model_reset();
    end else begin
      e_valid = exp_rd != 0;
      e_sop = 0; e_eop = 0; e_fr = 0; e_to = 0;
      if (exp_rd != 0) begin
        w = fq[m_grant][0];
        e_data = w.d;
        e_sop  = w.s;
        e_to   = !w.e && (m_cnt + 1 == MAXW);
        e_eop  = w.e || e_to;
        e_fr   = (m_cnt == 0) ? !w.s : w.s;
        m_cnt++;
        if (e_eop) m_busy = 0;
      end else if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          if (!found && pkt_avail[(m_last + k) % NP]) begin
            found = 1;
            m_grant = (m_last + k) % NP;
          end
        end
        if (found) begin
          m_last = m_grant; m_busy = 1; m_cnt = 0;
        end
      end
    end

    popv = rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (popv[i] && fq[i].size() > 0) begin
        w = fq[i].pop_front();
        if (w.e) npkts[i]--;
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((fq[0].size() > 0 || fq[1].size() > 0 || m_busy) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) check("drain_bound", 1, 0);
    step();
    step();
  endtask

  // Expected grant sequence: n grants alternating 0,1,0,1...
  task automatic check_grants(input string tag, input int n);
    check(tag, dut_grants.size(), n);
    for (int i = 0; i < n; i++)
      check(tag, (i < dut_grants.size()) ? dut_grants[i] : 99, i % 2);
  endtask

  initial begin
    int n;
    n_checks = 0; n_pass = 0; n_fr = 0; n_to = 0; prev_busy = 0;
    rst = 1'b1; out_ready = 1'b1; force_avail = '0;
    for (int i = 0; i < NP; i++) npkts[i] = 0;
    model_reset();

    step();
    step();
    check("rst_outvalid", outvalid, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);

    push_pkt(0, 3, 0, 1);
    push_pkt(1, 3, 0, 1);
    rst = 1'b0;
    dut_grants.delete();
    drain(100);
    check_grants("t1_grants", 2);

    dut_grants.delete();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, $urandom_range(1, 6), 0, 1);
      push_pkt(1, $urandom_range(1, 6), 0, 1);
    end
    drain(400);
    check_grants("t2_grants", 8);

    push_pkt(0, 8, 0, 1);
    repeat (3) step();
    out_ready = 1'b0;
    repeat (5) begin
      step();
      check("t3_rd_hold", rd_en, 0);
    end
    out_ready = 1'b1;
    drain(100);

    push_pkt(1, 70, 0, 0);
    force_avail = 2'b10;
    step();
    force_avail = '0;
    n_to = 0;
    n = 0;
    while (n_to == 0 && n < 200) begin
      step();
      n++;
    end
    step();
    step();
    check("t4_remaining", fq[1].size(), 6);
    check("t4_to_pulses", n_to, 1);
    fq[1].delete();

    n_fr = 0;
    push_pkt(0, 3, 1, 1);
    drain(100);
    check("t5_framing", n_fr, 1);

    push_pkt(1, 5, 0, 1);
    n = 0;
    while (!rd_en[1] && n < 20) begin
      step();
      n++;
    end
    check("t6_first_pop", rd_en, 2'b10);
    step();
    rst = 1'b1;
    #1;
    check("t6_rd_rst", rd_en, 0);
    step();
    rst = 1'b0;
    fq[1].delete();
    npkts[1] = 0;
    check("t6_busy_after_rst", busy, 0);
    check("t6_valid_after_rst", outvalid, 0);
    check("t6_data_after_rst", outdata, 0);
    push_pkt(0, 2, 0, 1);
    push_pkt(1, 2, 0, 1);
    dut_grants.delete();
    drain(100);
    check_grants("t6_grants", 2);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        int len;
        len = $urandom_range(1, 10);
        push_pkt($urandom_range(0, 1), len, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0, 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
